fm6126_cmd_rx: RTL and testbench

- Panel-side receiver for the FM6126 HUB75 configuration stream; the counterpart of the FM6126 init sequencer.
- Oversamples pixclock, latch and rgb lanes, recovers each 16-bit register word, and classifies every latch burst by the number of pixclock edges it spans: 12 means REG1, 13 means REG2, 3 means data latch.
- Used as an in-fabric loopback checker and simulation responder, so init-sequencer output can be checked against decoded register contents.

---
 rtl/fm6126_cmd_rx.sv | 195 +++++++++++++++++++
 tb/tb_fm6126_cmd_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fm6126_cmd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fm6126_cmd_rx : FM6126 HUB75 config-stream receiver / register decoder    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fm6126_cmd_rx #(
  parameter int LED_WIDTH  = 64,
  parameter int CHIP_WIDTH = 16,
  parameter int REG1_LATCH = 12,
  parameter int REG2_LATCH = 13,
  parameter int DATA_LATCH = 3
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  pixclock_in,
  input  logic                  latch_in,
  input  logic [2:0]            rgb1_in,
  input  logic [2:0]            rgb2_in,
  output logic                  reg_wr_valid,
  output logic [1:0]            reg_wr_sel,
  output logic [CHIP_WIDTH-1:0] reg_wr_data,
  output logic [CHIP_WIDTH-1:0] reg1_q,
  output logic [CHIP_WIDTH-1:0] reg2_q,
  output logic                  cfg_done,
  output logic                  proto_err,
  output logic [2:0]            err_code
);

  localparam int CNT_W = $clog2(2*LED_WIDTH) + 1;
  localparam int IDX_W = $clog2(CHIP_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2*LED_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ROW = CNT_W'(LED_WIDTH);
  localparam logic [3:0] L_REG1 = 4'(REG1_LATCH);
  localparam logic [3:0] L_REG2 = 4'(REG2_LATCH);
  localparam logic [3:0] L_DATA = 4'(DATA_LATCH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_LATCH  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_LCNT = 3'd1;
  localparam logic [2:0] E_ECNT = 3'd2;
  localparam logic [2:0] E_LANE = 3'd3;
  localparam logic [2:0] E_GAP  = 3'd4;

  logic [7:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  pix_prev_q, pix_prev_d, lat_prev_q, lat_prev_d;
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic [3:0]            latch_cnt_q, latch_cnt_d;
  logic [CHIP_WIDTH-1:0] shift_word_q, shift_word_d;
  logic                  reg_wr_valid_q, reg_wr_valid_d;
  logic [1:0]            reg_wr_sel_q, reg_wr_sel_d;
  logic [CHIP_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
  logic [CHIP_WIDTH-1:0] reg1_d, reg2_d;
  logic                  seen1_q, seen1_d, seen2_q, seen2_d;
  logic                  cfg_done_q, cfg_done_d;
  logic                  proto_err_q, proto_err_d;
  logic [2:0]            err_code_q, err_code_d;

  logic                  w_pix, w_lat, w_pe, w_lfall;
  logic [2:0]            w_rgb1, w_rgb2;
  logic                  w_commit, w_accept, w_lane_bad, w_gap;
  logic [1:0]            w_sel;
  logic [2:0]            w_evt;
  logic [CNT_W-1:0]      w_base_edge;
  logic [3:0]            w_base_latch;
  logic [CHIP_WIDTH-1:0] w_base_word;
  logic [IDX_W-1:0]      w_idx;

  always_comb begin
    sync1_d    = {pixclock_in, latch_in, rgb2_in, rgb1_in};
    sync2_d    = sync1_q;
    w_pix      = sync2_q[7];
    w_lat      = sync2_q[6];
    w_rgb2     = sync2_q[5:3];
    w_rgb1     = sync2_q[2:0];
    pix_prev_d = w_pix;
    lat_prev_d = w_lat;
    w_pe       = w_pix & ~pix_prev_q;
    w_lfall    = lat_prev_q & ~w_lat;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A pe landing in the COMMIT cycle starts the next burst rather than being dropped.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_COMMIT) begin
      if (w_pe) state_d = w_lat ? ST_LATCH : ST_SHIFT;
      else      state_d = ST_IDLE;
    end else if (w_lfall) begin
      state_d = ST_COMMIT;
    end else if (w_pe) begin
      if (w_lat)                  state_d = ST_LATCH;
      else if (state_q == ST_IDLE) state_d = ST_SHIFT;
    end
  end

  always_comb begin
    w_commit   = (state_q == ST_COMMIT);
    w_sel      = 2'd0;
    if (latch_cnt_q == L_REG1)      w_sel = 2'd1;
    else if (latch_cnt_q == L_REG2) w_sel = 2'd2;
    else if (latch_cnt_q == L_DATA) w_sel = 2'd3;
    w_accept   = w_commit && (edge_cnt_q == CNT_ROW) && (w_sel != 2'd0);
    w_lane_bad = w_pe && !((w_rgb1 == w_rgb2) && ((&w_rgb1) || (w_rgb1 == 3'd0)));
    w_gap      = w_pe && !w_lat && !w_lfall && (state_q == ST_LATCH);
    w_evt      = E_NONE;
    if (w_commit && (edge_cnt_q != CNT_ROW)) w_evt = E_ECNT;
    else if (w_commit && (w_sel == 2'd0))    w_evt = E_LCNT;
    else if (w_lane_bad)                     w_evt = E_LANE;
    else if (w_gap)                          w_evt = E_GAP;
  end

  always_comb begin
    w_base_edge  = w_commit ? '0 : edge_cnt_q;
    w_base_latch = w_commit ? 4'd0 : latch_cnt_q;
    w_base_word  = w_commit ? '0 : shift_word_q;
    w_idx        = w_base_edge[IDX_W-1:0];
    edge_cnt_d   = w_base_edge;
    latch_cnt_d  = w_base_latch;
    shift_word_d = w_base_word;
    if (w_pe) begin
      if (w_base_edge != CNT_MAX) edge_cnt_d = w_base_edge + 1'b1;
      shift_word_d[w_idx] = w_rgb1[0];
      if (w_lat && (w_base_latch != 4'hF)) latch_cnt_d = w_base_latch + 4'd1;
    end

    reg_wr_valid_d = w_accept;
    reg_wr_sel_d   = w_accept ? w_sel : reg_wr_sel_q;
    reg_wr_data_d  = w_accept ? shift_word_q : reg_wr_data_q;
    reg1_d         = (w_accept && w_sel == 2'd1) ? shift_word_q : reg1_q;
    reg2_d         = (w_accept && w_sel == 2'd2) ? shift_word_q : reg2_q;
    seen1_d        = seen1_q | (w_accept && w_sel == 2'd1);
    seen2_d        = seen2_q | (w_accept && w_sel == 2'd2);
    cfg_done_d     = seen1_d & seen2_d;
    proto_err_d    = proto_err_q | (w_evt != E_NONE);
    err_code_d     = (!proto_err_q && w_evt != E_NONE) ? w_evt : err_code_q;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      pix_prev_q     <= 1'b0;
      lat_prev_q     <= 1'b0;
      edge_cnt_q     <= '0;
      latch_cnt_q    <= 4'd0;
      shift_word_q   <= '0;
      reg_wr_valid_q <= 1'b0;
      reg_wr_sel_q   <= 2'd0;
      reg_wr_data_q  <= '0;
      reg1_q         <= '0;
      reg2_q         <= '0;
      seen1_q        <= 1'b0;
      seen2_q        <= 1'b0;
      cfg_done_q     <= 1'b0;
      proto_err_q    <= 1'b0;
      err_code_q     <= 3'd0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      pix_prev_q     <= pix_prev_d;
      lat_prev_q     <= lat_prev_d;
      edge_cnt_q     <= edge_cnt_d;
      latch_cnt_q    <= latch_cnt_d;
      shift_word_q   <= shift_word_d;
      reg_wr_valid_q <= reg_wr_valid_d;
      reg_wr_sel_q   <= reg_wr_sel_d;
      reg_wr_data_q  <= reg_wr_data_d;
      reg1_q         <= reg1_d;
      reg2_q         <= reg2_d;
      seen1_q        <= seen1_d;
      seen2_q        <= seen2_d;
      cfg_done_q     <= cfg_done_d;
      proto_err_q    <= proto_err_d;
      err_code_q     <= err_code_d;
    end
  end

  assign reg_wr_valid = reg_wr_valid_q;
  assign reg_wr_sel   = reg_wr_sel_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign cfg_done     = cfg_done_q;
  assign proto_err    = proto_err_q;
  assign err_code     = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_fm6126_cmd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fm6126_cmd_rx : scoreboard bench for the FM6126 config receiver        |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fm6126_cmd_rx;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        pixclock_in = 1'b0;
  logic        latch_in = 1'b0;
  logic [2:0]  rgb1_in = 3'd0;
  logic [2:0]  rgb2_in = 3'd0;
  logic        reg_wr_valid;
  logic [1:0]  reg_wr_sel;
  logic [15:0] reg_wr_data, reg1_q, reg2_q;
  logic        cfg_done, proto_err;
  logic [2:0]  err_code;

  fm6126_cmd_rx dut (
    .clk_in(clk_in), .reset(reset), .pixclock_in(pixclock_in), .latch_in(latch_in),
    .rgb1_in(rgb1_in), .rgb2_in(rgb2_in), .reg_wr_valid(reg_wr_valid),
    .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data), .reg1_q(reg1_q),
    .reg2_q(reg2_q), .cfg_done(cfg_done), .proto_err(proto_err), .err_code(err_code)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        cfg;
    logic        perr;
    logic [2:0]  ec;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  exp_t e;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest pending expectation.
  always @(negedge clk_in) begin
    if (reset && reg_wr_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got sel=%0d data=%0h expected no write", reg_wr_sel, reg_wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_sel", 32'(reg_wr_sel), 32'(e.sel));
        chk("wr_data", 32'(reg_wr_data), 32'(e.data));
        chk("reg1_q", 32'(reg1_q), 32'(e.r1));
        chk("reg2_q", 32'(reg2_q), 32'(e.r2));
        chk("cfg_done", 32'(cfg_done), 32'(e.cfg));
        chk("proto_err", 32'(proto_err), 32'(e.perr));
        chk("err_code", 32'(err_code), 32'(e.ec));
        chk("latency", 32'(cyc - fall_cyc), 32'd4);
      end
    end
  end

  task automatic expect_wr(input logic [1:0] s, input logic [15:0] d, input logic [15:0] r1,
                           input logic [15:0] r2, input logic c, input logic p, input logic [2:0] ec);
    exp_t x;
    x.sel = s; x.data = d; x.r1 = r1; x.r2 = r2; x.cfg = c; x.perr = p; x.ec = ec;
    sb.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(reg_wr_valid), 32'd0);
    chk({tag, "_sel"}, 32'(reg_wr_sel), 32'd0);
    chk({tag, "_data"}, 32'(reg_wr_data), 32'd0);
    chk({tag, "_reg1"}, 32'(reg1_q), 32'd0);
    chk({tag, "_reg2"}, 32'(reg2_q), 32'd0);
    chk({tag, "_cfg"}, 32'(cfg_done), 32'd0);
    chk({tag, "_perr"}, 32'(proto_err), 32'd0);
    chk({tag, "_ecode"}, 32'(err_code), 32'd0);
  endtask

  task automatic pix_edge(input logic b, input logic l, input logic flip);
    @(negedge clk_in);
    pixclock_in = 1'b0;
    latch_in    = l;
    rgb1_in     = {3{b}};
    rgb2_in     = {3{b}};
    if (flip) rgb2_in[1] = ~b;
    repeat (3) @(negedge clk_in);
    pixclock_in = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic quiet_reset(input string tag);
    @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    check_all_zero(tag);
    pixclock_in = 1'b0; latch_in = 1'b0; rgb1_in = 3'd0; rgb2_in = 3'd0;
    repeat (4) @(negedge clk_in);
    reset = 1'b1;
    repeat (6) @(negedge clk_in);
  endtask

  // Edge i carries word bit i%16; latch is high across the last nl edges.
  task automatic burst(input int n, input int nl, input logic [15:0] w, input int flip_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        quiet_reset("midrst");
        return;
      end
      pix_edge(w[i % 16], (i >= n - nl), (i == flip_at));
    end
    @(negedge clk_in);
    pixclock_in = 1'b0;
    latch_in    = 1'b0;
    fall_cyc    = cyc;
    repeat (12) @(negedge clk_in);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk_in);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending writes expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk_in);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk_in);

    expect_wr(2'd1, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 3'd0);
    burst(64, 12, 16'h7FFF, -1, -1);
    drain("reg1");

    expect_wr(2'd2, 16'h0040, 16'h7FFF, 16'h0040, 1'b1, 1'b0, 3'd0);
    burst(64, 13, 16'h0040, -1, -1);
    drain("reg2");

    expect_wr(2'd3, 16'hA5C3, 16'h7FFF, 16'h0040, 1'b1, 1'b0, 3'd0);
    burst(64, 3, 16'hA5C3, -1, -1);
    drain("data");

    burst(63, 12, 16'h1111, -1, -1);
    chk("short_perr", 32'(proto_err), 32'd1);
    chk("short_ecode", 32'(err_code), 32'd2);
    chk("short_reg1", 32'(reg1_q), 32'h7FFF);

    expect_wr(2'd1, 16'h1234, 16'h1234, 16'h0040, 1'b1, 1'b1, 3'd2);
    burst(64, 12, 16'h1234, -1, -1);
    drain("after_err");

    quiet_reset("rst2");
    burst(64, 11, 16'h5555, -1, -1);
    chk("lcnt_perr", 32'(proto_err), 32'd1);
    chk("lcnt_ecode", 32'(err_code), 32'd1);
    chk("lcnt_reg1", 32'(reg1_q), 32'd0);

    quiet_reset("rst3");
    expect_wr(2'd1, 16'h8001, 16'h8001, 16'h0000, 1'b0, 1'b1, 3'd3);
    burst(64, 12, 16'h8001, 5, -1);
    drain("lane");

    burst(64, 12, 16'h7FFF, -1, 30);
    expect_wr(2'd2, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 3'd0);
    burst(64, 13, 16'hBEEF, -1, -1);
    drain("post_rst");
    chk("final_reg1", 32'(reg1_q), 32'd0);
    chk("final_sel", 32'(reg_wr_sel), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
